// File: rtl/multiport_memory_system_pkg.sv
// Shared types and constants for the multiport memory system: FSM state
// encoding, port-count ceiling and the bytes-per-word helper.
package mem_sys_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam int MAX_PORTS = 4;

  function automatic int bytesOf(input int dataWidth);
    return dataWidth / 8;
  endfunction

endpackage

// File: rtl/multiport_memory_system_if.sv
// Request/response bundle shared by all requester ports of the memory system.
// The master side belongs to the requesters; the slave side to the memory.
interface multiport_memory_system_if #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 32
);

  logic [NUM_PORTS-1:0]                   req_valid;
  logic [NUM_PORTS-1:0]                   req_ready;
  logic [NUM_PORTS-1:0][31:0]             req_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   req_wdata;
  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] req_wstrb;
  logic [NUM_PORTS-1:0]                   rsp_valid;
  logic [NUM_PORTS-1:0]                   rsp_ready;
  logic [DATA_WIDTH-1:0]                  rsp_rdata;
  logic                                   rsp_err;
  logic                                   busy;

  modport master (
    output req_valid, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/multiport_memory_system_byte_sram.sv
// Behavioural single-port SRAM with per-byte write enables, standing in for the
// vendor macro. Array read is asynchronous; READ_LATENCY-1 output registers follow.
module byte_sram
  import mem_sys_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_DEPTH    = 16384,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_WIDTH   = $clog2(MEM_DEPTH)
) (
  input  logic                           clk_i,
  input  logic                           en_i,
  input  logic [bytesOf(DATA_WIDTH)-1:0] we_i,
  input  logic [ADDR_WIDTH-1:0]          addr_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  output logic [DATA_WIDTH-1:0]          rdata_o
);

  localparam int NB = bytesOf(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] readWord;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < NB; b++) begin
        if (we_i[b]) begin
          mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign readWord = mem[addr_i];

  // The requester's response register acts as the final latency stage.
  if (READ_LATENCY == 1) begin : g_direct
    assign rdata_o = readWord;
  end else begin : g_pipe
    logic [DATA_WIDTH-1:0] stage_q [READ_LATENCY-1];

    always_ff @(posedge clk_i) begin
      if (en_i) begin
        stage_q[0] <= readWord;
      end
      for (int s = 1; s < READ_LATENCY - 1; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end

    assign rdata_o = stage_q[READ_LATENCY-2];
  end

endmodule

// File: rtl/multiport_memory_system.sv
// Round-robin arbitrated access from NUM_PORTS requesters to one shared byte-strobed
// SRAM, one transaction in flight at a time, with out-of-range error responses.
module multiport_memory_system
  import mem_sys_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_DEPTH    = 16384,
  parameter int ADDR_LSB     = 2,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_WIDTH   = $clog2(MEM_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  multiport_memory_system_if.slave  bus
);

  localparam int NB    = bytesOf(DATA_WIDTH);
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_t                state_q;
  logic [PTR_W-1:0]      ptr_q;
  logic [PTR_W-1:0]      port_q;
  logic [ADDR_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         wstrb_q;
  logic [1:0]            cnt_q;
  logic [DATA_WIDTH-1:0] rspRdata_q;
  logic                  rspErr_q;

  logic                  grantValid;
  logic [PTR_W-1:0]      grantIdx;
  logic [PTR_W-1:0]      cand;
  logic [PTR_W-1:0]      nextPtr;
  logic [31:0]           selWord;
  logic                  selErr;
  logic                  accept;
  logic [NUM_PORTS-1:0]  reqReady;
  logic [NUM_PORTS-1:0]  rspValid;
  logic                  sramEn;
  logic [NB-1:0]         sramWe;
  logic [DATA_WIDTH-1:0] sramRdata;

  // First valid port at or after the pointer wins, wrapping around.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % NUM_PORTS);
      if (!grantValid && bus.req_valid[cand]) begin
        grantValid = 1'b1;
        grantIdx   = cand;
      end
    end
  end

  assign nextPtr = (int'(grantIdx) == NUM_PORTS - 1) ? '0 : grantIdx + 1'b1;
  assign selWord = bus.req_addr[grantIdx] >> ADDR_LSB;
  assign selErr  = selWord >= 32'(MEM_DEPTH);
  assign accept  = (state_q == S_IDLE) && grantValid && !rst;

  always_comb begin
    reqReady = '0;
    rspValid = '0;
    if (accept) begin
      reqReady[grantIdx] = 1'b1;
    end
    if (state_q == S_RESP) begin
      rspValid[port_q] = 1'b1;
    end
  end

  assign bus.req_ready = reqReady;
  assign bus.rsp_valid = rspValid;
  assign bus.rsp_rdata = rspRdata_q;
  assign bus.rsp_err   = rspErr_q;
  assign bus.busy      = (state_q != S_IDLE);

  // Enable only on the first ACCESS cycle; a reset in that cycle kills the write.
  assign sramEn = (state_q == S_ACCESS) && (cnt_q == 2'(READ_LATENCY - 1)) && !rst;
  assign sramWe = sramEn ? wstrb_q : '0;

  byte_sram #(
    .DATA_WIDTH   (DATA_WIDTH),
    .MEM_DEPTH    (MEM_DEPTH),
    .READ_LATENCY (READ_LATENCY),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_sram (
    .clk_i   (clk),
    .en_i    (sramEn),
    .we_i    (sramWe),
    .addr_i  (word_q),
    .wdata_i (wdata_q),
    .rdata_o (sramRdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      port_q     <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      cnt_q      <= '0;
      rspRdata_q <= '0;
      rspErr_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grantValid) begin
            port_q  <= grantIdx;
            ptr_q   <= nextPtr;
            word_q  <= selWord[ADDR_WIDTH-1:0];
            wdata_q <= bus.req_wdata[grantIdx];
            wstrb_q <= bus.req_wstrb[grantIdx];
            cnt_q   <= 2'(READ_LATENCY - 1);
            if (selErr) begin
              state_q    <= S_RESP;
              rspErr_q   <= 1'b1;
              rspRdata_q <= '0;
            end else begin
              state_q <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (cnt_q == 2'd0) begin
            state_q    <= S_RESP;
            rspErr_q   <= 1'b0;
            rspRdata_q <= (|wstrb_q) ? '0 : sramRdata;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready[port_q]) begin
            state_q    <= S_IDLE;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/multiport_memory_system.md
Name: multiport_memory_system

Overview:
- Parametrised successor to the single-port word memory. Serves NUM_PORTS requesters (e.g. instruction fetch + load/store) from one shared single-port SRAM through a round-robin arbiter.
- Each port uses a valid/ready request and response handshake.
- Adds true per-byte write strobes, configurable SRAM read latency, and address-range error responses.
- Sits between the core's memory stages and the on-chip data SRAM.

Parameters:
- NUM_PORTS, 2, number of requester ports (1..4)
- DATA_WIDTH, 32, data word width; must be a multiple of 8
- MEM_DEPTH, 16384, number of words
- ADDR_LSB, 2, byte-address bits below the word index; equals log2(DATA_WIDTH/8)
- READ_LATENCY, 1, SRAM read latency in cycles (1..3)
- ADDR_WIDTH, $clog2(MEM_DEPTH), word index width (derived)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_PORTS  request valid per port
- req_ready  out  NUM_PORTS  request accepted this cycle when valid&ready
- req_addr  in  NUM_PORTS x 32  byte address
- req_wdata  in  NUM_PORTS x DATA_WIDTH  write data
- req_wstrb  in  NUM_PORTS x DATA_WIDTH/8  byte strobes; all-zero means read
- rsp_valid  out  NUM_PORTS  response valid per port
- rsp_ready  in  NUM_PORTS  response consumed when valid&ready
- rsp_rdata  out  DATA_WIDTH  read data, shared bus; meaningful for the port whose rsp_valid is high
- rsp_err  out  1  response carries an address error
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: one clk and one rst port. rst is synchronous and active-high and has priority over everything.
  - State goes to IDLE and the round-robin pointer goes to 0.
  - req_ready, rsp_valid, rsp_err, busy and rsp_rdata all reset to 0.
  - SRAM contents are not cleared.
- Only one transaction is in flight at a time.
- FSM states are IDLE, ACCESS, RESP.
- IDLE:
  - Grant goes to the first port with req_valid, searching from the pointer upward with wrap.
  - req_ready is driven combinationally for the granted port only; all other ports see 0.
  - On accept, capture port, word index, wdata and wstrb, and set the pointer to (granted+1) mod NUM_PORTS.
  - Next state is ACCESS, or RESP if the address is out of range.
  - With no valid request, stay in IDLE.
- Range check: error if the word index computed from addr[31:ADDR_LSB] is >= MEM_DEPTH. Low address bits addr[ADDR_LSB-1:0] are ignored.
- Error responses:
  - Go straight to RESP with rsp_err=1 and rsp_rdata=0.
  - No SRAM enable and no write.
- ACCESS:
  - The SRAM enable is asserted in the first ACCESS cycle only.
  - Write: byte lane i is written iff wstrb[i]; unstrobed lanes keep their old value.
  - ACCESS lasts exactly READ_LATENCY cycles, tracked by a down-counter.
  - On the last ACCESS cycle the SRAM output is registered into rsp_rdata, then the state moves to RESP.
  - Writes return rsp_rdata=0 and rsp_err=0.
- Latency: rsp_valid rises READ_LATENCY+1 clock edges after the accept edge. For error responses it rises 1 edge after accept.
- RESP:
  - rsp_valid is high for the captured port only.
  - rsp_rdata and rsp_err are held stable until rsp_ready.
  - On valid&ready, next state is IDLE.
  - A new request cannot be accepted in the same cycle; minimum throughput is one transaction per READ_LATENCY+2 cycles.
- Read-after-write to the same word returns the new data; no SRAM bypass is needed because there is no overlap.
- Simultaneous requests: exactly one port is granted per accept. The others keep req_valid high and must not see req_ready.
- Reset mid-operation:
  - Any in-flight response is dropped.
  - An SRAM write is suppressed if rst is high in its ACCESS cycle. The SRAM write enable is gated by !rst.
- Requests arriving while busy are not accepted (req_ready=0) and are not lost; the requester holds them.

Decomposition:
- Package mem_sys_pkg holds:
  - state_t {S_IDLE, S_ACCESS, S_RESP}
  - the BYTES = DATA_WIDTH/8 helper
  - the MAX_PORTS = 4 constant
- Sub-module byte_sram:
  - Single port, per-byte write enable.
  - READ_LATENCY-deep output pipeline.
  - Parameterised on DATA_WIDTH, MEM_DEPTH and READ_LATENCY.
  - Behavioural model in simulation, swappable for the vendor IP.
- Arbiter and FSM stay in the top module.

Test Plan:
1. Port0 write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF; after the response, port0 read 0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid exactly READ_LATENCY+1 edges after accept.
2. Byte strobes: word 0x20 holds 0x11223344; write 0xAABBCCDD with wstrb 0x5, then read -> 0x11BB33DD.
3. Round robin: both ports hold req_valid continuously from reset with reads -> grants alternate p0, p1, p0, p1; no port is granted twice in a row.
4. Out of range: read at byte address 4*MEM_DEPTH -> rsp_err 1, rsp_rdata 0, rsp_valid 1 edge after accept; the word at index 0 (alias) is unmodified.
5. Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 on all ports; release -> IDLE on the next edge.
6. Reset mid-ACCESS: word 0x40 holds 0x0; accept a write of 0xFFFFFFFF and assert rst during its ACCESS cycle -> all outputs 0, state IDLE; a subsequent read of 0x40 returns 0x0.
